// File: rtl/note_pkg.sv
// Note table shared by the key beeper and the tone decoder, plus decoder types.
package note_pkg;

  localparam int unsigned CNT_W  = 21;
  localparam int unsigned NOTE_N = 22;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned BASE_CLK_HZ = 50_000_000;

  localparam logic [1:0] PITCH_LO  = 2'b00;
  localparam logic [1:0] PITCH_MID = 2'b01;
  localparam logic [1:0] PITCH_HI  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_t;

  // Half-period in 50 MHz cycles; indices 0-7 octave 00, 8-14 octave 01, 15-21 octave 11
  function automatic logic [CNT_W-1:0] note_half(input logic [IDX_W-1:0] idx);
    case (idx)
      5'd0:    note_half = 21'd95566;
      5'd1:    note_half = 21'd85131;
      5'd2:    note_half = 21'd75843;
      5'd3:    note_half = 21'd71586;
      5'd4:    note_half = 21'd63776;
      5'd5:    note_half = 21'd56818;
      5'd6:    note_half = 21'd50619;
      5'd7:    note_half = 21'd47774;
      5'd8:    note_half = 21'd42568;
      5'd9:    note_half = 21'd37919;
      5'd10:   note_half = 21'd35793;
      5'd11:   note_half = 21'd31888;
      5'd12:   note_half = 21'd28409;
      5'd13:   note_half = 21'd25310;
      5'd14:   note_half = 21'd23821;
      5'd15:   note_half = 21'd21284;
      5'd16:   note_half = 21'd18961;
      5'd17:   note_half = 21'd17896;
      5'd18:   note_half = 21'd15944;
      5'd19:   note_half = 21'd14205;
      5'd20:   note_half = 21'd12655;
      5'd21:   note_half = 21'd11911;
      default: note_half = '0;
    endcase
  endfunction

  // Beeper reload value: it toggles every count+1 cycles
  function automatic logic [CNT_W-1:0] note_count(input logic [IDX_W-1:0] idx);
    note_count = note_half(idx) - CNT_W'(1);
  endfunction

  function automatic logic [2:0] note_key_num(input logic [IDX_W-1:0] idx);
    if (idx < 5'd8)       note_key_num = idx[2:0];
    else if (idx < 5'd15) note_key_num = 3'(idx - 5'd7);
    else                  note_key_num = 3'(idx - 5'd14);
  endfunction

  function automatic logic [7:0] note_key(input logic [IDX_W-1:0] idx);
    note_key = ~(8'd1 << note_key_num(idx));
  endfunction

  function automatic logic [1:0] note_pitch(input logic [IDX_W-1:0] idx);
    if (idx < 5'd8)       note_pitch = PITCH_LO;
    else if (idx < 5'd15) note_pitch = PITCH_MID;
    else                  note_pitch = PITCH_HI;
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronizes the tone input, detects both edges and measures the cycles between them.
module tone_period_meter
  import note_pkg::*;
#(
  parameter int unsigned TIMEOUT = 200_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tone,
  output logic             o_m_vld,
  output logic [CNT_W-1:0] o_m,
  output logic             o_timeout
);

  logic [2:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_m;
  logic             r_m_vld;
  logic             r_to;
  logic             w_edge;

  assign w_edge    = r_sync[2] ^ r_sync[1];
  assign o_m_vld   = r_m_vld;
  assign o_m       = r_m;
  assign o_timeout = r_to;

  // Counter restarts at 1 so the value seen at the next edge equals the full spacing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_m     <= '0;
      r_m_vld <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], i_tone};
      r_m_vld <= w_edge;
      r_to    <= 1'b0;
      if (w_edge) begin
        r_m   <= r_cnt;
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != CNT_W'(TIMEOUT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_to  <= (r_cnt == CNT_W'(TIMEOUT - 1));
      end
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// Classifies measured tone half-periods against the note table and locks onto a stable note.
module tone_decoder
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TOL_SHIFT = 6,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned MIN_HALF  = 11_000,
  parameter int unsigned TIMEOUT   = 200_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [7:0]       key_out,
  output logic [1:0]       pitch_out,
  output logic             note_valid,
  output logic             note_strobe,
  output logic [CNT_W-1:0] half_period
);

  localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);

  logic             w_m_vld;
  logic [CNT_W-1:0] w_m;
  logic             w_timeout;
  logic [CNT_W-1:0] w_tab [NOTE_N];
  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_diff;
  logic             w_hit;
  logic             w_short;
  logic [RUN_W-1:0] w_run_nx;

  state_t           r_state;
  logic             r_busy;
  logic [IDX_W-1:0] r_idx;
  logic             r_res_vld;
  logic             r_res_match;
  logic [IDX_W-1:0] r_res_idx;
  logic [IDX_W-1:0] r_cand;
  logic             r_cand_vld;
  logic [RUN_W-1:0] r_run;
  logic [IDX_W-1:0] r_note;
  logic [7:0]       r_key;
  logic [1:0]       r_pitch;
  logic             r_valid;
  logic             r_strobe;

  tone_period_meter #(.TIMEOUT(TIMEOUT)) u_meter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tone    (tone_in),
    .o_m_vld   (w_m_vld),
    .o_m       (w_m),
    .o_timeout (w_timeout)
  );

  // Table rescaled at elaboration when running from a clock other than 50 MHz
  for (genvar g = 0; g < NOTE_N; g++) begin : g_tab
    localparam logic [63:0] H_SC = (64'(note_half(IDX_W'(g))) * 64'(CLK_HZ)
                                    + 64'(BASE_CLK_HZ / 2)) / 64'(BASE_CLK_HZ);
    assign w_tab[g] = CNT_W'(H_SC);
  end

  assign w_h     = w_tab[r_idx];
  assign w_hit   = (w_diff <= (w_h >> TOL_SHIFT));
  assign w_short = (w_m < CNT_W'(MIN_HALF)) || (w_m == CNT_W'(TIMEOUT));

  always_comb begin
    w_diff   = (w_m >= w_h) ? (w_m - w_h) : (w_h - w_m);
    w_run_nx = RUN_W'(1);
    if (r_cand_vld && (r_cand == r_res_idx)) w_run_nx = r_run + RUN_W'(1);
  end

  assign key_out     = r_key;
  assign pitch_out   = r_pitch;
  assign note_valid  = r_valid;
  assign note_strobe = r_strobe;
  assign half_period = w_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_idx       <= '0;
      r_res_vld   <= 1'b0;
      r_res_match <= 1'b0;
      r_res_idx   <= '0;
      r_cand      <= '0;
      r_cand_vld  <= 1'b0;
      r_run       <= '0;
      r_note      <= '0;
      r_key       <= 8'hFF;
      r_pitch     <= PITCH_MID;
      r_valid     <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_strobe  <= 1'b0;
      r_res_vld <= 1'b0;

      // Sequential search; a new measurement abandons any search in flight
      if (w_m_vld) begin
        r_busy <= 1'b0;
        if (r_state != ST_IDLE) begin
          if (w_short) begin
            r_res_vld   <= 1'b1;
            r_res_match <= 1'b0;
          end else begin
            r_busy <= 1'b1;
            r_idx  <= '0;
          end
        end
      end else if (r_busy) begin
        if (w_hit) begin
          r_busy      <= 1'b0;
          r_res_vld   <= 1'b1;
          r_res_match <= 1'b1;
          r_res_idx   <= r_idx;
        end else if (r_idx == IDX_W'(NOTE_N - 1)) begin
          r_busy      <= 1'b0;
          r_res_vld   <= 1'b1;
          r_res_match <= 1'b0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end

      if (w_timeout) begin
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_res_vld  <= 1'b0;
        r_cand_vld <= 1'b0;
        r_run      <= '0;
        r_valid    <= 1'b0;
        r_key      <= 8'hFF;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_m_vld) begin
              r_state    <= ST_ACQUIRE;
              r_cand_vld <= 1'b0;
              r_run      <= '0;
            end
          end
          ST_ACQUIRE: begin
            if (r_res_vld) begin
              if (r_res_match) begin
                r_cand     <= r_res_idx;
                r_cand_vld <= 1'b1;
                if (w_run_nx >= RUN_W'(LOCK_CNT)) begin
                  r_state  <= ST_LOCKED;
                  r_note   <= r_res_idx;
                  r_key    <= note_key(r_res_idx);
                  r_pitch  <= note_pitch(r_res_idx);
                  r_valid  <= 1'b1;
                  r_strobe <= 1'b1;
                  r_run    <= '0;
                end else begin
                  r_run <= w_run_nx;
                end
              end else begin
                r_run <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (r_res_vld && !(r_res_match && (r_res_idx == r_note))) begin
              r_state    <= ST_ACQUIRE;
              r_valid    <= 1'b0;
              r_key      <= 8'hFF;
              r_cand     <= r_res_idx;
              r_cand_vld <= r_res_match;
              r_run      <= r_res_match ? RUN_W'(1) : '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder; table scaled to a 1 MHz clock (values /50) for short runs.
module tb_tone_decoder;

  logic        clk;
  logic        rst_n;
  logic        tone_in;
  logic [7:0]  key_out;
  logic [1:0]  pitch_out;
  logic        note_valid;
  logic        note_strobe;
  logic [20:0] half_period;

  int n_cmp    = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int n_bad    = 0;
  int since_tgl = 0;

  tone_decoder #(
    .CLK_HZ    (1_000_000),
    .TOL_SHIFT (6),
    .LOCK_CNT  (4),
    .MIN_HALF  (220),
    .TIMEOUT   (4000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .key_out     (key_out),
    .pitch_out   (pitch_out),
    .note_valid  (note_valid),
    .note_strobe (note_strobe),
    .half_period (half_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (note_strobe) n_strobe++;
      if (note_strobe && !note_valid) n_bad++;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    tone_in = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    since_tgl = 0;
  endtask

  // n toggles spaced h cycles; the first one accounts for time already spent in settle()
  task automatic tone(input int h, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (h - ((i == 0) ? since_tgl : 0)) @(posedge clk);
      #1 tone_in = ~tone_in;
      since_tgl = 0;
    end
  endtask

  task automatic settle(input int k);
    repeat (k) @(posedge clk);
    #1;
    since_tgl += k;
  endtask

  initial begin
    tone_in = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_key",    32'(key_out),     32'hFF);
    chk("reset_pitch",  32'(pitch_out),   32'h1);
    chk("reset_valid",  32'(note_valid),  32'h0);
    chk("reset_strobe", 32'(note_strobe), 32'h0);
    chk("reset_half",   32'(half_period), 32'h0);
    rst_n = 1'b1;

    // Low C: 4 edges are not enough, the 5th locks
    do_reset();
    tone(1911, 4);
    settle(40);
    chk("lowc_prelock_valid", 32'(note_valid), 32'h0);
    tone(1911, 1);
    settle(40);
    chk("lowc_valid",   32'(note_valid),  32'h1);
    chk("lowc_key",     32'(key_out),     32'hFE);
    chk("lowc_pitch",   32'(pitch_out),   32'h0);
    chk("lowc_half",    32'(half_period), 32'd1911);
    chk("lowc_strobes", 32'(n_strobe),    32'd1);

    // Shared value resolves to the lower octave
    do_reset();
    tone(955, 5);
    settle(40);
    chk("shared_valid", 32'(note_valid), 32'h1);
    chk("shared_key",   32'(key_out),    32'h7F);
    chk("shared_pitch", 32'(pitch_out),  32'h0);

    // Tolerance edge: 256 vs 253 is exactly the tolerance of 3
    do_reset();
    tone(256, 5);
    settle(40);
    chk("tol_valid",   32'(note_valid), 32'h1);
    chk("tol_key",     32'(key_out),    32'hBF);
    chk("tol_pitch",   32'(pitch_out),  32'h3);
    chk("tol_strobes", 32'(n_strobe),   32'd3);

    // Just outside tolerance, then between E4 and F4
    do_reset();
    tone(257, 6);
    settle(40);
    chk("tol_out_valid", 32'(note_valid), 32'h0);
    tone(1474, 6);
    settle(40);
    chk("gap_valid",   32'(note_valid), 32'h0);
    chk("gap_key",     32'(key_out),    32'hFF);
    chk("gap_strobes", 32'(n_strobe),   32'd3);

    // Silence after lock on G4
    do_reset();
    tone(1276, 5);
    settle(40);
    chk("sil_lock_valid", 32'(note_valid), 32'h1);
    chk("sil_lock_key",   32'(key_out),    32'hEF);
    settle(3950);
    chk("sil_before_to_valid", 32'(note_valid), 32'h1);
    settle(30);
    chk("sil_after_to_valid", 32'(note_valid), 32'h0);
    chk("sil_after_to_key",   32'(key_out),    32'hFF);
    chk("sil_pitch_held",     32'(pitch_out),  32'h0);
    chk("sil_strobes",        32'(n_strobe),   32'd4);

    // Note change D5 -> E5
    do_reset();
    tone(851, 5);
    settle(40);
    chk("chg_d5_key",   32'(key_out),   32'hFD);
    chk("chg_d5_pitch", 32'(pitch_out), 32'h1);
    tone(758, 1);
    settle(40);
    chk("chg_drop_valid", 32'(note_valid), 32'h0);
    chk("chg_drop_key",   32'(key_out),    32'hFF);
    chk("chg_drop_pitch", 32'(pitch_out),  32'h1);
    tone(758, 2);
    settle(40);
    chk("chg_run3_valid", 32'(note_valid), 32'h0);
    tone(758, 1);
    settle(40);
    chk("chg_relock_valid", 32'(note_valid), 32'h1);
    chk("chg_relock_key",   32'(key_out),    32'hFB);
    chk("chg_relock_pitch", 32'(pitch_out),  32'h1);
    chk("chg_strobes",      32'(n_strobe),   32'd6);

    // Asynchronous reset while locked
    rst_n = 1'b0;
    #2;
    chk("arst_key",    32'(key_out),     32'hFF);
    chk("arst_pitch",  32'(pitch_out),   32'h1);
    chk("arst_valid",  32'(note_valid),  32'h0);
    chk("arst_strobe", 32'(note_strobe), 32'h0);
    chk("arst_half",   32'(half_period), 32'h0);

    // Short half-period never locks
    do_reset();
    tone(100, 8);
    settle(40);
    chk("short_valid",   32'(note_valid),  32'h0);
    chk("short_half",    32'(half_period), 32'd100);
    chk("short_strobes", 32'(n_strobe),    32'd6);

    chk("strobe_without_valid", 32'(n_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
